fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, 2..8), is the instruction buffer depth and the maximum number of outstanding requests.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  out  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  in  1  response valid; always accepted, no ready.
REQ-009 imem_rsp_data  in  32  instruction word, returned in request order.
REQ-010 redirect_valid  in  1  flush and restart fetch (branch, jump or trap).
REQ-011 redirect_pc  in  32  new fetch address; bits [1:0] are ignored.
REQ-012 if_valid  out  1  instruction available to decode.
REQ-013 if_ready  in  1  decode accepts it this cycle.
REQ-014 if_instr  out  32  instruction word for decode and immediate generation.
REQ-015 if_pc  out  32  address of if_instr.

Function
REQ-016 A request fires on imem_req_valid && imem_req_ready, and fetch_pc then advances by 4.
REQ-017 imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
  - Every response has a guaranteed buffer slot.
REQ-018 imem_req_addr = {fetch_pc[31:2], 2'b00}.
  - Holds stable while imem_req_valid is high and not accepted, unless a redirect occurs.
REQ-019 outstanding updates each cycle by (+1 on request fire) and (-1 on response).
REQ-020 A response with drop_cnt == 0 is pushed into the FIFO along with its PC.
  - Its PC comes from a parallel PC queue written at request fire.
REQ-021 A response with drop_cnt != 0 is discarded, and drop_cnt decrements.
REQ-022 if_valid = FIFO not empty; if_instr and if_pc come straight from the head registers.
  - No combinational path from imem_rsp_* to if_*; minimum response-to-if_valid latency is 1 cycle.
REQ-023 Pop on if_valid && if_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Order is preserved.
REQ-024 On redirect_valid, at the next edge:
  - fetch_pc <= {redirect_pc[31:2], 2'b00};
  - FIFO and PC queue are cleared;
  - drop_cnt <= outstanding − (imem_rsp_valid ? 1 : 0), which discards every in-flight response;
  - a response arriving in the redirect cycle is also discarded.
REQ-025 No request is issued in the redirect cycle; fetching resumes the following cycle at the new PC.
REQ-026 Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
REQ-027 if_valid is not gated by redirect_valid; the downstream stage flushes anything popped in the redirect cycle.
REQ-028 fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-029 A response received while outstanding == 0 is a protocol error; it is ignored and the counters do not underflow.

Reset
REQ-030 While rst_n is low:
  - fetch_pc = RESET_PC;
  - outstanding = 0, drop_cnt = 0, fifo_count = 0;
  - imem_req_valid = 0 and if_valid = 0, immediately (asynchronous).
REQ-031 The first request is presented in the first clock cycle after rst_n rises, with addr = RESET_PC.
REQ-032 Reset asserted mid-operation abandons all in-flight requests.
  - The memory side must also be reset; no drop accounting survives reset.

Structure
REQ-033 The shared package riscv_pkg holds XLEN = 32, ILEN = 32, NOP_INSTR = 32'h0000_0013 and the default RESET_PC.
REQ-034 One sub-module, fetch_fifo: a synchronous FIFO of width 64 ({pc, instr}), depth FIFO_DEPTH, with flush, count, and the same clock and reset.
REQ-035 Counters are $clog2(FIFO_DEPTH)+1 bits wide; the expected size is 150–300 lines of RTL in total.

Verification
REQ-036 Reset release, memory always ready, 1-cycle latency, if_ready = 1 → requests at 0x0, 0x4, 0x8…; if_pc/if_instr follow in order, one per cycle after fill.
REQ-037 if_ready = 0 for 10 cycles → at most 4 requests issued, if_valid held with if_pc = 0x0, no overflow; resume → no loss or duplication.
REQ-038 imem_req_ready = 0 for 3 cycles → imem_req_addr stays 0x8 throughout; accepted on the 4th cycle.
REQ-039 Two requests in flight (0x10, 0x14), then redirect_pc = 0x103 → both responses dropped; the next request addr is 0x100, and the first if_pc is 0x100.
REQ-040 Redirect in the same cycle as a response, then a second redirect to 0x200 one cycle later → only 0x200-stream instructions reach if_*.
REQ-041 Redirect to 0xFFFF_FFFC → fetches at 0xFFFF_FFFC then 0x0; reset asserted mid-stream → if_valid = 0 at once, restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ISA widths, reset defaults and the fetch buffer entry layout
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int ENTRY_W = XLEN + ILEN;

    // Buffer entry as stored in fetch_fifo: PC in the upper half, instruction below
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] instr);
        return {pc, instr};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, instr} buffer with flush, occupancy count and registered head
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] data_i,
    input  logic               pop_i,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] data_o,
    output logic [CW-1:0]      count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign valid_o = cnt_q != '0;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointer and occupancy next state; flush empties the buffer and wins over push/pop
    always_comb begin
        do_push = push_i && (cnt_q != CW'(DEPTH));
        do_pop  = pop_i && valid_o;
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        cnt_d   = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only observed through a valid count
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests, redirect flush and drop accounting
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]      outst_q, outst_d, drop_q, drop_d;
    logic [XLEN-1:0]    pcq_q [FIFO_DEPTH];
    logic [AW-1:0]      pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    logic [CW-1:0]      fifo_cnt;
    logic [CW:0]        inflight;
    logic               req_ok, fire, rsp_ok, push;
    logic [ENTRY_W-1:0] head;
    logic               unused_bits;

    // Every issued request already owns a buffer slot, so responses can never overflow the FIFO
    assign inflight       = {1'b0, outst_q} + {1'b0, fifo_cnt};
    assign req_ok         = !redirect_valid && (inflight < (CW+1)'(FIFO_DEPTH));
    assign fire           = req_ok && imem_req_ready;
    assign imem_req_valid = rst_n && req_ok;
    assign imem_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};
    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_ok         = imem_rsp_valid && (outst_q != '0);
    assign if_pc          = head[ENTRY_W-1:ILEN];
    assign if_instr       = head[ILEN-1:0];
    assign unused_bits    = ^redirect_pc[1:0];

    // Fetch PC, outstanding/drop counters and PC-queue pointers; redirect discards all in-flight work
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(fire) - CW'(rsp_ok);
        drop_d     = drop_q;
        pq_wr_d    = pq_wr_q;
        pq_rd_d    = pq_rd_q;
        push       = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = outst_q - CW'(rsp_ok);
            pq_wr_d    = '0;
            pq_rd_d    = '0;
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pq_wr_d    = pq_wr_q + AW'(1);
            end
            if (rsp_ok && drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else if (rsp_ok) begin
                push    = 1'b1;
                pq_rd_d = pq_rd_q + AW'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
            outst_q    <= '0;
            drop_q     <= '0;
            pq_wr_q    <= '0;
            pq_rd_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            pq_wr_q    <= pq_wr_d;
            pq_rd_q    <= pq_rd_d;
        end
    end

    // PC queue: records each request address so the matching response can be tagged in order
    always_ff @(posedge clk) begin
        if (fire) pcq_q[pq_wr_q] <= fetch_pc_q;
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .data_i  (pack_entry(pcq_q[pq_rd_q], imem_rsp_data)),
        .pop_i   (if_ready),
        .valid_o (if_valid),
        .data_o  (head),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a queue-based 1-cycle memory
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic [31:0] mq [$];
    int          fires = 0;
    logic        mem_hold = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          w;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    // Memory: accepted addresses queue up; one response per cycle, instruction = ~address
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                fires = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                mq.push_back(imem_req_addr);
                fires++;
            end
            @(posedge clk);
            #2;
            if (rst_n && !mem_hold && mq.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~mq.pop_front();
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic ifr, input logic rqr, input logic hold);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        redirect_valid = 1'b0;
        if_ready       = ifr;
        imem_req_ready = rqr;
        mem_hold       = hold;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pop_chk(input logic [31:0] pc, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!if_valid && waited < 20);
        chk("pop_valid", if_valid, 1);
        chk("pop_pc", if_pc, pc);
        chk("pop_instr", if_instr, ~pc);
    endtask

    initial begin
        if_ready       = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Streaming after reset: requests 0,4,8 and one instruction per cycle
        do_reset(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("a_req_valid", imem_req_valid, 1);
        chk("a_req_addr", imem_req_addr, 32'h0);
        pop_chk(32'h0, w);
        chk("a_first_latency", w, 2);
        pop_chk(32'h4, w);
        chk("a_gap1", w, 1);
        pop_chk(32'h8, w);
        chk("a_gap2", w, 1);

        // Decode stalled 10 cycles: exactly 4 requests, head held at 0
        do_reset(1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("b_if_valid", if_valid, 1);
        chk("b_if_pc", if_pc, 32'h0);
        chk("b_req_valid", imem_req_valid, 0);
        @(posedge clk);
        #1;
        chk("b_fires", fires, 4);
        if_ready = 1'b1;
        pop_chk(32'h0, w);
        pop_chk(32'h4, w);
        pop_chk(32'h8, w);
        pop_chk(32'hC, w);
        pop_chk(32'h10, w);

        // Memory not ready for 3 cycles: address 8 held, then accepted
        do_reset(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 imem_req_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("c_hold_valid", imem_req_valid, 1);
            chk("c_hold_addr", imem_req_addr, 32'h8);
        end
        @(posedge clk);
        #1 imem_req_ready = 1'b1;
        @(negedge clk);
        chk("c_accept_addr", imem_req_addr, 32'h8);
        @(negedge clk);
        chk("c_next_addr", imem_req_addr, 32'hC);
        @(posedge clk);
        #1 if_ready = 1'b1;
        pop_chk(32'h0, w);
        pop_chk(32'h4, w);
        pop_chk(32'h8, w);

        // Two requests in flight (0x10, 0x14) dropped by redirect to 0x103
        do_reset(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("d_addr10", imem_req_addr, 32'h10);
        @(negedge clk);
        chk("d_addr14", imem_req_addr, 32'h14);
        @(posedge clk);
        #1 imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        chk("d_no_req_in_redirect", imem_req_valid, 0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        mem_hold = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("d_resume_valid", imem_req_valid, 1);
        chk("d_resume_addr", imem_req_addr, 32'h100);
        pop_chk(32'h100, w);
        pop_chk(32'h104, w);

        // Redirect with a response in the same cycle, then a second redirect to 0x200
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        chk("e_rsp_during_redirect", imem_rsp_valid, 1);
        chk("e_no_req_r1", imem_req_valid, 0);
        @(posedge clk);
        #1 redirect_pc = 32'h200;
        @(negedge clk);
        chk("e_no_req_r2", imem_req_valid, 0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        pop_chk(32'h200, w);
        pop_chk(32'h204, w);
        pop_chk(32'h208, w);

        // Wrap at the top of the address space, low bits of redirect_pc ignored
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("f_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        pop_chk(32'hFFFF_FFFC, w);
        pop_chk(32'h0, w);
        pop_chk(32'h4, w);

        // Reset mid-stream: outputs drop at once, fetch restarts at RESET_PC
        chk("f_stream_active", if_valid, 1);
        do_reset(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("f_restart_addr", imem_req_addr, 32'h0);
        pop_chk(32'h0, w);
        pop_chk(32'h4, w);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
